// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide issue controller:
// instruction classes, datapath op codes, controller states and default latencies.
package md_pkg;

    // MD class of the instruction sitting in D
    localparam logic [2:0] CLS_NONE   = 3'd0;
    localparam logic [2:0] CLS_MULT   = 3'd1;
    localparam logic [2:0] CLS_MULTU  = 3'd2;
    localparam logic [2:0] CLS_DIV    = 3'd3;
    localparam logic [2:0] CLS_DIVU   = 3'd4;
    localparam logic [2:0] CLS_MFHI   = 3'd5;
    localparam logic [2:0] CLS_MFLO   = 3'd6;
    localparam logic [2:0] CLS_MTHILO = 3'd7;

    // Op handed to the datapath together with md_start
    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    // Classes that start a multi-cycle operation
    function automatic logic is_start_cls(input logic [2:0] cls);
        return (cls == CLS_MULT) || (cls == CLS_MULTU) ||
               (cls == CLS_DIV)  || (cls == CLS_DIVU);
    endfunction

    function automatic md_op_e cls_to_op(input logic [2:0] cls);
        md_op_e op;
        case (cls)
            CLS_MULT:  op = OP_MULT;
            CLS_MULTU: op = OP_MULTU;
            CLS_DIV:   op = OP_DIV;
            CLS_DIVU:  op = OP_DIVU;
            default:   op = OP_MULT;
        endcase
        return op;
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Load / decrement / zero-detect down-counter that times the MD unit latency.
// Clear has priority over load, load over decrement.
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count selection
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the HI/LO multiply/divide unit at the D/E boundary.
// Issues a one-cycle md_start, times the unit latency, pulses md_commit at completion
// and stalls D while an MD instruction would hit HI/LO in flight.
// Optional feature: define MD_FLUSH_EN to add the e_flush abort input.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MD_FLUSH_EN
    input  logic             e_flush,
`endif
    input  logic             d_valid,
    input  logic [2:0]       d_cls,
    input  logic             d_advance,
    output logic             stall_md,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             mt_we,
    output logic             md_commit,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    // Counter reload values: the issue edge itself consumes one cycle of latency
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_e        state_q;
    md_op_e           op_q;
    md_op_e           op_d;
    logic             flush_s;
    logic             run_s;
    logic             gate_s;
    logic             issue_s;
    logic             commit_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] load_val_s;

`ifdef MD_FLUSH_EN
    assign flush_s = e_flush;
`else
    assign flush_s = 1'b0;
`endif

    assign run_s    = (state_q == ST_RUN);
    assign stall_md = d_valid & (d_cls != CLS_NONE) & run_s;
    // A flush in the issue cycle kills the instruction in D as well
    assign gate_s   = d_valid & d_advance & ~stall_md & ~flush_s;
    assign issue_s  = gate_s & is_start_cls(d_cls);
    assign commit_s = run_s & cnt_zero_s;

    // Op being latched this cycle decides which latency gets loaded
    always_comb begin
        op_d       = op_q;
        load_val_s = MUL_LOAD;
        if (issue_s) begin
            op_d = cls_to_op(d_cls);
        end else begin
            op_d = op_q;
        end
        if (op_is_div(op_d)) begin
            load_val_s = DIV_LOAD;
        end else begin
            load_val_s = MUL_LOAD;
        end
    end

    // Controller FSM: IDLE until issue, RUN until commit or flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_q <= ST_RUN;
                        op_q    <= op_d;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (commit_s || flush_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (run_s & flush_s & ~cnt_zero_s),
        .load_i     (issue_s),
        .load_val_i (load_val_s),
        .dec_i      (run_s & ~cnt_zero_s),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero_s)
    );

    assign md_start  = issue_s;
    assign md_op     = issue_s ? cls_to_op(d_cls) : OP_MULT;
    assign mt_we     = gate_s & (d_cls == CLS_MTHILO);
    assign md_commit = commit_s;
    assign busy      = run_s;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl. Expected commit cycles are
// queued when an op is issued and compared when md_commit is observed.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam int CNT_W   = 4;

    localparam logic [2:0] C_NONE   = 3'd0;
    localparam logic [2:0] C_MULT   = 3'd1;
    localparam logic [2:0] C_MULTU  = 3'd2;
    localparam logic [2:0] C_DIV    = 3'd3;
    localparam logic [2:0] C_DIVU   = 3'd4;
    localparam logic [2:0] C_MFHI   = 3'd5;
    localparam logic [2:0] C_MFLO   = 3'd6;
    localparam logic [2:0] C_MTHILO = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic             e_flush;
    logic             d_valid;
    logic [2:0]       d_cls;
    logic             d_advance;
    logic             stall_md;
    logic             md_start;
    logic [1:0]       md_op;
    logic             mt_we;
    logic             md_commit;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mon_exp;
    int n0;

    md_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MD_FLUSH_EN
        .e_flush   (e_flush),
`endif
        .d_valid   (d_valid),
        .d_cls     (d_cls),
        .d_advance (d_advance),
        .stall_md  (stall_md),
        .md_start  (md_start),
        .md_op     (md_op),
        .mt_we     (mt_we),
        .md_commit (md_commit),
        .busy      (busy),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Inputs change just after the rising edge; checks happen at the falling edge
    task automatic drive(input logic v, input logic [2:0] c, input logic a);
        @(posedge clk);
        #1;
        d_valid   = v;
        d_cls     = c;
        d_advance = a;
        @(negedge clk);
    endtask

    // Scoreboard: every commit must match the oldest expected commit cycle
    always @(negedge clk) begin
        if (reset === 1'b0 && md_commit === 1'b1) begin
            mon_exp = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
            checks++;
            assert (cyc === mon_exp) else begin
                errors++;
                $error("FAIL commit_cycle: observed=%0d expected=%0d", cyc, mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1; e_flush = 1'b0;
        d_valid = 1'b0; d_cls = C_NONE; d_advance = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_commit", md_commit, 0);
        @(posedge clk); #1 reset = 1'b0;
        drive(1'b0, C_NONE, 1'b0);
        chk("idle_busy", busy, 0);

        // MULT followed by MFLO waiting in D
        drive(1'b1, C_MULT, 1'b1);
        chk("mult_start", md_start, 1);
        chk("mult_op", md_op, 0);
        chk("mult_stall", stall_md, 0);
        exp_q.push_back(cyc + MUL_LAT);
        for (int k = 1; k <= MUL_LAT; k++) begin
            drive(1'b1, C_MFLO, 1'b1);
            chk("mflo_busy", busy, 1);
            chk("mflo_stall", stall_md, 1);
            chk("mflo_cnt", cnt, MUL_LAT - k);
            chk("mflo_commit", md_commit, (k == MUL_LAT) ? 1 : 0);
        end
        drive(1'b1, C_MFLO, 1'b1);
        chk("mflo_go_busy", busy, 0);
        chk("mflo_go_stall", stall_md, 0);
        chk("mflo_go_start", md_start, 0);
        chk("mflo_go_mtwe", mt_we, 0);

        // DIVU then DIV back to back
        drive(1'b1, C_DIVU, 1'b1);
        chk("divu_start", md_start, 1);
        chk("divu_op", md_op, 3);
        n0 = cyc;
        exp_q.push_back(cyc + DIV_LAT);
        for (int k = 1; k <= DIV_LAT; k++) begin
            drive(1'b1, C_DIV, 1'b1);
            chk("div_wait_start", md_start, 0);
            chk("div_wait_stall", stall_md, 1);
        end
        drive(1'b1, C_DIV, 1'b1);
        chk("div_start", md_start, 1);
        chk("div_op", md_op, 2);
        chk("div_gap", cyc - n0, DIV_LAT + 1);
        exp_q.push_back(cyc + DIV_LAT);

        // Non-MD stream (and invalid MD) during RUN never stalls
        for (int k = 1; k <= DIV_LAT; k++) begin
            drive(k[0], (k[0] ? C_NONE : C_MULTU), 1'b1);
            chk("nonmd_busy", busy, 1);
            chk("nonmd_stall", stall_md, 0);
            chk("nonmd_start", md_start, 0);
        end
        drive(1'b0, C_NONE, 1'b0);
        chk("div_done_busy", busy, 0);

        // MTHILO while idle, with and without advance
        drive(1'b1, C_MTHILO, 1'b1);
        chk("mt_we_adv", mt_we, 1);
        chk("mt_start", md_start, 0);
        drive(1'b1, C_MTHILO, 1'b0);
        chk("mt_we_noadv", mt_we, 0);
        chk("mt_busy", busy, 0);
        drive(1'b1, C_MFHI, 1'b1);
        chk("mfhi_idle_stall", stall_md, 0);

        // No advance: MULT must not issue
        drive(1'b1, C_MULT, 1'b0);
        chk("noadv_start", md_start, 0);
        drive(1'b0, C_NONE, 1'b0);
        chk("noadv_busy", busy, 0);

        // Asynchronous reset in the middle of RUN
        drive(1'b1, C_MULTU, 1'b1);
        chk("multu_op", md_op, 1);
        exp_q.push_back(cyc + MUL_LAT);
        drive(1'b0, C_NONE, 1'b0);
        drive(1'b0, C_NONE, 1'b0);
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cnt", cnt, 0);
        void'(exp_q.pop_back());
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            drive(1'b0, C_NONE, 1'b0);
            chk("post_rst_busy", busy, 0);
        end

`ifdef MD_FLUSH_EN
        // Flush three cycles into a DIV: abort, no commit
        drive(1'b1, C_DIV, 1'b1);
        chk("fl_div_start", md_start, 1);
        for (int k = 1; k <= 3; k++) drive(1'b0, C_NONE, 1'b0);
        e_flush = 1'b1;
        drive(1'b0, C_NONE, 1'b0);
        e_flush = 1'b0;
        chk("fl_idle_busy", busy, 0);
        chk("fl_idle_cnt", cnt, 0);
        // Flush in the commit cycle: commit still happens
        drive(1'b1, C_MULT, 1'b1);
        exp_q.push_back(cyc + MUL_LAT);
        for (int k = 1; k <= MUL_LAT; k++) drive(1'b0, C_NONE, 1'b0);
        e_flush = 1'b1;
        #1 chk("fl_commit", md_commit, 1);
        drive(1'b0, C_NONE, 1'b0);
        chk("fl_commit_after", busy, 0);
        // Flush in the issue cycle suppresses start and mt_we
        drive(1'b1, C_MULT, 1'b1);
        chk("fl_issue_start", md_start, 0);
        drive(1'b1, C_MTHILO, 1'b1);
        chk("fl_mtwe", mt_we, 0);
        chk("fl_issue_busy", busy, 0);
        e_flush = 1'b0;
`endif

        repeat (3) drive(1'b0, C_NONE, 1'b0);
        chk("pending_commits", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and sequencing controller for the HI/LO multiply/divide unit in the 5-stage MIPS pipeline.
- Sits at the D/E boundary. Classifies the MD-related instruction in D, issues a one-cycle start to the unit, and times the unit's latency with its own counter.
- Pulses the HI/LO commit at completion and stalls D while an MD-dependent instruction would conflict.
- Replaces ad-hoc Busy/count logic inside the unit; the unit becomes a pure datapath latched by md_start and md_commit.

Parameters:
- MUL_LAT, 5, cycles from issue edge to commit for MULT/MULTU (must be ≥1).
- DIV_LAT, 10, cycles from issue edge to commit for DIV/DIVU (must be ≥1).
- CNT_W, 4, counter width; must satisfy 2**CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  D-stage holds a valid instruction.
- d_cls  in  3  MD class of D instruction: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHILO.
- d_advance  in  1  pipeline would move D→E this cycle (no other stall source).
- stall_md  out  1  MD-induced stall request for F/D.
- md_start  out  1  one-cycle start pulse to the MD datapath (combinational, the issue cycle).
- md_op  out  2  op for md_start: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; 0 when md_start low.
- mt_we  out  1  MTHI/MTLO write-enable pulse (issue cycle of class 7).
- md_commit  out  1  one-cycle pulse; datapath copies result into HI/LO on this edge.
- busy  out  1  operation in flight.
- cnt  out  CNT_W  remaining cycles (debug/observability).

Behaviour:
- Reset (async, any state) forces state IDLE, cnt=0, busy=0, md_commit=0, latched op=0. Combinational outputs follow from state.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- stall_md = d_valid & (d_cls≠NONE) & busy. Applies to every MD class, including MF*/MT* (HI/LO RAW/WAW hazard).
- issue = d_valid & d_advance & ~stall_md & d_cls∈{1..4}.
  - md_start=issue; md_op decoded from d_cls.
  - On that edge: state←RUN, cnt←LAT−1 (MUL_LAT or DIV_LAT).
  - Latched op selects which latency.
- mt_we = d_valid & d_advance & ~stall_md & d_cls==7. No state change.
- RUN: cnt decrements each cycle.
  - md_commit = RUN & cnt==0. Next edge → IDLE.
  - Timing: issue edge N; busy high cycles N+1..N+LAT; md_commit in cycle N+LAT; busy low from N+LAT+1.
- Commit cycle still stalls MD instructions in D; they issue the cycle after, so MFHI/MFLO read committed HI/LO.
- d_advance low: no issue, no mt_we. Stall still computed.
- Back-to-back MULT/DIV: the second issues exactly in cycle N+LAT+1; no overlap ever.
- Non-MD classes never stall.
- Reset mid-RUN: abort immediately, no md_commit.

Optional Feature:
- MD_FLUSH_EN defined:
  - Adds input e_flush (1 bit).
  - e_flush high in RUN → next edge IDLE, cnt=0, no md_commit (HI/LO untouched).
  - e_flush in the same cycle as a commit lets the commit proceed.
  - e_flush in the issue cycle suppresses md_start, md_commit and mt_we.
- Undefined: port absent; an issued op always completes.

Decomposition:
- md_pkg holds:
  - class encoding constants (CLS_NONE..CLS_MTHILO);
  - md_op encodings;
  - state encoding (ST_IDLE, ST_RUN);
  - default latencies.
- One natural sub-module: md_lat_counter. Load/decrement/zero-detect down-counter, parameterised by CNT_W, with async reset.

Test Plan:
- Reset mid-RUN → busy=0 asynchronously, no md_commit afterwards.
- MULT issued at cycle 10, MFLO in D at cycle 11 → busy cycles 11–15, md_commit in 15, stall_md cycles 11–15, MFLO issues in cycle 16.
- DIVU then immediate DIV → md_op=3 then 2, md_start at cycles N and N+11, md_commit at N+10 and N+21.
- MTHILO while idle with d_advance=1 → mt_we=1 for one cycle, busy stays 0. Same instruction with d_advance=0 → mt_we=0.
- Non-MD instruction stream during RUN → stall_md=0 throughout.
- (MD_FLUSH_EN) e_flush at cycle N+3 of DIV → IDLE at N+4, no md_commit. e_flush exactly in the commit cycle → md_commit still pulses.
